// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: bit-serial Montgomery modular exponentiation a^d mod n of generic width
module rsa_modexp_core #(
  parameter int WIDTH = 256,
  localparam int LW = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [LW-1:0]    i_d_len,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_a_pow_e,
  output logic             o_finished,
  output logic             o_busy,
  output logic             o_error
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, MONT, FIX, ERR, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] d_r, n_r, m, t, res, t_prep, red_m, red_t;
  logic [WIDTH+1:0] acc_m, acc_t, sum_m, sum_t, step_m, step_t;
  logic [WIDTH:0]   dbl;
  logic [LW-1:0]    len_r, len, k, kn;
  logic [CW-1:0]    i;
  logic             err, illegal, go, last_i, dk, tb;
  assign go      = state == IDLE && i_start && !i_abort;
  assign illegal = !i_n[0] || i_n < WIDTH'(3);
  assign len     = (i_d_len == '0 || i_d_len > LW'(WIDTH)) ? LW'(WIDTH) : i_d_len;
  assign last_i  = i == CW'(WIDTH - 1);
  assign kn      = k + LW'(1);
  assign dk      = d_r[k[CW-1:0]];
  assign tb      = t[i];
  assign o_a_pow_e  = res;
  assign o_error    = err;
  assign o_finished = state == DONE;
  assign o_busy     = state == PREP || state == MONT || state == FIX;
  // Doubling step for a*2^W mod n, one interleaved Montgomery step per product, and final reductions
  always_comb begin
    dbl    = {t, 1'b0};
    t_prep = dbl >= {1'b0, n_r} ? WIDTH'(dbl - {1'b0, n_r}) : dbl[WIDTH-1:0];
    sum_m  = acc_m + (tb ? {2'b0, m} : '0);
    sum_t  = acc_t + (tb ? {2'b0, t} : '0);
    step_m = (sum_m[0] ? sum_m + {2'b0, n_r} : sum_m) >> 1;
    step_t = (sum_t[0] ? sum_t + {2'b0, n_r} : sum_t) >> 1;
    red_m  = WIDTH'(acc_m >= {2'b0, n_r} ? acc_m - {2'b0, n_r} : acc_m);
    red_t  = WIDTH'(acc_t >= {2'b0, n_r} ? acc_t - {2'b0, n_r} : acc_t);
  end
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  // Next state; abort overrides every transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = i_start ? (illegal ? ERR : PREP) : IDLE;
      PREP:    nxt = last_i ? MONT : PREP;
      MONT:    nxt = last_i ? FIX : MONT;
      FIX:     nxt = kn == len_r ? DONE : MONT;
      ERR:     nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (i_abort) nxt = IDLE;
  end
  // Operand latch, datapath registers, result and error flag
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      d_r <= '0; n_r <= '0; len_r <= '0; m <= '0; t <= '0; k <= '0; i <= '0;
      acc_m <= '0; acc_t <= '0; res <= '0; err <= 1'b0;
    end else begin
      if (go) begin
        d_r <= i_d; n_r <= i_n; len_r <= len; m <= WIDTH'(1); t <= i_a;
        k <= '0; i <= '0; acc_m <= '0; acc_t <= '0; err <= 1'b0;
      end
      if (state == PREP) begin
        t <= t_prep;
        i <= last_i ? '0 : i + CW'(1);
      end
      if (state == MONT) begin
        acc_t <= step_t;
        if (dk) acc_m <= step_m;
        i <= last_i ? '0 : i + CW'(1);
      end
      if (state == FIX) begin
        t <= red_t;
        if (dk) m <= red_m;
        k <= kn;
        acc_m <= '0;
        acc_t <= '0;
        if (nxt == DONE) res <= dk ? red_m : m;
      end
      if (state == ERR && nxt == DONE) begin
        res <= '0;
        err <= 1'b1;
      end
    end
endmodule
